// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: one-frame skid buffer feeding a BCLK/LRCK/DATA serialiser.
// Repeats the last frame and counts an underrun when no new frame is waiting at frame start.
module i2s_dac_tx #(
    parameter int DATA_W    = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              frame_req,
    output logic              underrun,
    output logic [7:0]        underrun_cnt,
    output logic              AUD_BCLK,
    output logic              AUD_DACLRCK,
    output logic              AUD_DACDAT
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(DATA_W);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } frame_t;

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             bclk, lrck, dat;
    logic             buf_full;
    frame_t           buf_frame, act_frame;
    logic             frame_req_q, underrun_q;
    logic [7:0]       ur_cnt;

    logic             div_wrap, fall_tick, frame_start, accept;
    logic [CNT_W-1:0] bit_next, pos;
    logic             right_slot, dat_next;
    logic [DATA_W-1:0] slot_sample;

    always_comb begin
        div_wrap    = (div_cnt == DIV_LAST);
        fall_tick   = div_wrap && bclk;
        frame_start = fall_tick && (bit_cnt == BIT_LAST);
        bit_next    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        right_slot  = (bit_next >= SLOT_LEN);
        pos         = right_slot ? bit_next - SLOT_LEN : bit_next;
        slot_sample = right_slot ? act_frame.right : act_frame.left;
        accept      = in_valid && !buf_full;
        // pos 1 carries the MSB; pos 0 and the slot tail never match and stay 0
        dat_next = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (pos == POS_LAST - CNT_W'(i)) dat_next = slot_sample[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt     <= '0;
            bclk        <= 1'b0;
            lrck        <= 1'b0;
            dat         <= 1'b0;
            bit_cnt     <= BIT_LAST;
            buf_full    <= 1'b0;
            buf_frame   <= '0;
            act_frame   <= '0;
            frame_req_q <= 1'b0;
            underrun_q  <= 1'b0;
            ur_cnt      <= '0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) bclk <= !bclk;
            if (fall_tick) begin
                bit_cnt <= bit_next;
                lrck    <= right_slot;
                dat     <= dat_next;
            end
            frame_req_q <= frame_start;
            underrun_q  <= frame_start && !buf_full;
            if (frame_start) begin
                if (buf_full) act_frame <= buf_frame;
                else if (ur_cnt != 8'hFF) ur_cnt <= ur_cnt + 8'd1;
            end
            // transfer requires full and accept requires empty, so these never collide
            if (frame_start && buf_full) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full  <= 1'b1;
                buf_frame <= '{left: left_in, right: right_in};
            end
        end
    end

    assign in_ready     = !buf_full;
    assign frame_req    = frame_req_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ur_cnt;
    assign AUD_BCLK     = bclk;
    assign AUD_DACLRCK  = lrck;
    assign AUD_DACDAT   = dat;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: frame-level model feeds an expected-frame queue that an I2S
// deserialiser drains; a second fast instance exercises underrun counter saturation.
module tb_i2s_dac_tx;
    localparam int DW = 16, SB = 32, DIV = 2;
    localparam int FRAME_CYC = 2 * SB * 2 * DIV;
    localparam int FIRST     = 2 * DIV;
    localparam int BIT_CYC   = 2 * DIV;
    localparam int SB2 = 17, DIV2 = 1;
    localparam int FRAME2 = 2 * SB2 * 2 * DIV2;
    localparam int FIRST2 = 2 * DIV2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_sat;
    logic [DW-1:0] left_in, right_in;
    logic in_valid;
    logic in_ready, frame_req, underrun, bclk, lrck, dat;
    logic [7:0] ucnt_dut;
    logic [DW-1:0] zero_l, zero_r;
    logic zero_v;
    logic s_ready, s_req, s_ur, s_bclk, s_lrck, s_dat;
    logic [7:0] s_cnt;

    i2s_dac_tx #(.DATA_W(DW), .SLOT_BITS(SB), .BCLK_DIV(DIV)) dut (
        .Clk(clk), .Reset(rst), .left_in(left_in), .right_in(right_in), .in_valid(in_valid),
        .in_ready(in_ready), .frame_req(frame_req), .underrun(underrun), .underrun_cnt(ucnt_dut),
        .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat));

    i2s_dac_tx #(.DATA_W(DW), .SLOT_BITS(SB2), .BCLK_DIV(DIV2)) sat (
        .Clk(clk), .Reset(rst_sat), .left_in(zero_l), .right_in(zero_r), .in_valid(zero_v),
        .in_ready(s_ready), .frame_req(s_req), .underrun(s_ur), .underrun_cnt(s_cnt),
        .AUD_BCLK(s_bclk), .AUD_DACLRCK(s_lrck), .AUD_DACDAT(s_dat));

    int passed = 0, total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // frame-level reference model, advanced once per clock edge
    int n = 0, gen = 0, ucnt = 0;
    bit full = 0, exp_fr = 0, exp_ur = 0, in_rst = 0, armed = 0;
    logic [31:0] bufm = 0, actm = 0;
    logic [31:0] expq[$];

    always @(posedge clk) begin
        bit fs, acc;
        if (rst) begin
            n = 0; full = 0; bufm = 0; actm = 0; ucnt = 0;
            exp_fr = 0; exp_ur = 0; in_rst = 1; armed = 1;
            expq.delete(); gen++;
        end else begin
            in_rst = 0;
            n++;
            fs  = (n >= FIRST) && ((n - FIRST) % FRAME_CYC == 0);
            acc = in_valid && !full;
            exp_fr = fs;
            exp_ur = fs && !full;
            if (fs) begin
                if (full) begin actm = bufm; full = 0; end
                else if (ucnt < 255) ucnt++;
                expq.push_back(actm);
            end
            if (acc) begin bufm = {left_in, right_in}; full = 1; end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            int b;
            b = (n >= FIRST) ? ((n - FIRST) / BIT_CYC) % (2 * SB) : 0;
            chk("bclk", 32'(bclk), 32'((n / DIV) % 2));
            chk("lrck", 32'(lrck), 32'((n >= FIRST) && (b >= SB)));
            chk("in_ready", 32'(in_ready), 32'(!full));
            chk("frame_req", 32'(frame_req), 32'(exp_fr));
            chk("underrun", 32'(underrun), 32'(exp_ur));
            chk("underrun_cnt", 32'(ucnt_dut), 32'(ucnt));
            if (in_rst) chk("rst_dat", 32'(dat), 32'd0);
        end
    end

    // codec-side deserialiser: sample DACDAT on each BCLK rise
    int mon_gen = 0, rise_k = 0;
    logic last_bclk = 1'b0;
    bit fb[64];

    always @(negedge clk) begin
        if (mon_gen != gen) begin
            mon_gen = gen; rise_k = 0; last_bclk = 1'b0;
        end else begin
            if (bclk === 1'b1 && last_bclk === 1'b0) begin
                int idx, bi;
                logic [15:0] l, r;
                logic pad;
                logic [31:0] e;
                rise_k++;
                idx = rise_k - 2;
                if (idx >= 0) begin
                    bi = idx % 64;
                    fb[bi] = (dat === 1'b1);
                    if (bi == 63) begin
                        l = '0; r = '0; pad = fb[0] | fb[32];
                        for (int j = 0; j < 16; j++) begin
                            l[15-j] = fb[1+j];
                            r[15-j] = fb[33+j];
                        end
                        for (int j = 17; j < 32; j++) pad = pad | fb[j] | fb[j+32];
                        if (expq.size() == 0) begin
                            total++;
                            $display("FAIL frame_queue: frame on wire L=%h R=%h, expected none", l, r);
                        end else begin
                            e = expq.pop_front();
                            chk("frame_left", 32'(l), 32'(e[31:16]));
                            chk("frame_right", 32'(r), 32'(e[15:0]));
                            chk("frame_pad", 32'(pad), 32'd0);
                        end
                    end
                end
            end
            last_bclk = bclk;
        end
    end

    // saturation instance: never fed, so every frame start is an underrun
    int sn = 0;
    bit sat_arm = 0;
    always @(posedge clk) begin
        if (rst_sat) begin sn = 0; sat_arm = 1; end
        else sn++;
    end
    always @(negedge clk) begin
        if (sat_arm) begin
            int fr;
            fr = (sn >= FIRST2) ? (sn - FIRST2) / FRAME2 + 1 : 0;
            chk("sat_cnt", 32'(s_cnt), 32'((fr > 255) ? 255 : fr));
        end
    end

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        bit acc;
        int waitc;
        left_in = l; right_in = r; in_valid = 1'b1;
        acc = 0; waitc = 0;
        while (!acc && waitc < 2000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            waitc++;
        end
        if (!acc) begin
            total++;
            $display("FAIL offer_timeout: in_ready stayed 0, expected acceptance within 2000 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_n(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 30000) begin @(posedge clk); #1; guard++; end
    endtask

    initial begin
        rst = 1; rst_sat = 1; in_valid = 0; left_in = '0; right_in = '0;
        zero_l = '0; zero_r = '0; zero_v = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 0; rst_sat = 0;

        offer(16'h8001, 16'h7FFE);
        wait_n(FIRST + 2 * FRAME_CYC + 10);

        offer(16'hA5C3, 16'h1234);
        offer(16'h0F0F, 16'hFFFF);

        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 400)) @(posedge clk);
            #1;
            offer(16'($urandom), 16'($urandom));
        end

        // reset mid left slot, while pos 8 is on the wire
        begin
            int guard;
            guard = 0;
            @(posedge clk); #1;
            while (!(n > FIRST && ((n - FIRST) % FRAME_CYC) == 8 * BIT_CYC) && guard < 1000) begin
                @(posedge clk); #1; guard++;
            end
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        wait_n(FIRST + 10);

        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 300)) @(posedge clk);
            #1;
            offer(16'($urandom), 16'($urandom));
        end

        begin
            int guard;
            guard = 0;
            while (sn < FIRST2 + FRAME2 * 305 && guard < 40000) begin
                @(posedge clk); #1; guard++;
            end
        end
        wait_n(n + 2 * FRAME_CYC);
        @(negedge clk);
        chk("sat_final", 32'(s_cnt), 32'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
